// File: rtl/wb_stream_pkg.sv
// Shared constants for the stream-to-memory writer: Wishbone cycle/burst
// type codes and the controller state encoding.
package wb_stream_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/wb_stream_writer_ctrl_if.sv
// Wishbone B3 master-side bundle used by the stream writer.
// Handshake: a beat completes on a rising clk edge where cyc, stb and ack are all high.
interface wb_stream_writer_ctrl_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic [AW-1:0]   wbm_adr_o;
  logic [DW-1:0]   wbm_dat_o;
  logic [DW/8-1:0] wbm_sel_o;
  logic            wbm_we_o;
  logic            wbm_cyc_o;
  logic            wbm_stb_o;
  logic [2:0]      wbm_cti_o;
  logic [1:0]      wbm_bte_o;
  logic            wbm_ack_i;
  logic            wbm_err_i;

  modport master (
    output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o,
           wbm_stb_o, wbm_cti_o, wbm_bte_o,
    input  wbm_ack_i, wbm_err_i
  );

  modport slave (
    input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o,
           wbm_stb_o, wbm_cti_o, wbm_bte_o,
    output wbm_ack_i, wbm_err_i
  );

endinterface

// File: rtl/wb_stream_writer_ctrl.sv
// Drains a FWFT stream FIFO into a memory buffer using Wishbone incrementing
// write bursts; a burst is only issued once all of its words are in the FIFO.
module wb_stream_writer_ctrl
  import wb_stream_pkg::*;
#(
  parameter int WB_AW         = 32,
  parameter int WB_DW         = 32,
  parameter int FIFO_AW       = 5,
  parameter int MAX_BURST_LEN = 128
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WB_AW-1:0]   cfg_start_adr,
  input  logic [WB_AW-1:0]   cfg_buf_size,
  input  logic [15:0]        cfg_burst_size,
  output logic               busy,
  output logic               irq,
  output logic               err,
  input  logic [WB_DW-1:0]   fifo_d,
  input  logic [FIFO_AW:0]   fifo_cnt,
  output logic               fifo_rd,
  wb_stream_writer_ctrl_if.master wbm,
  output state_t             state_o
);

  localparam int WSB = WB_DW / 8;

  state_t           state_q, state_d;
  logic [WB_AW-1:0] adr_q, adr_d;
  logic [WB_AW-1:0] rem_q, rem_d;
  logic [15:0]      bsz_q, bsz_d;
  logic [15:0]      beat_q, beat_d;
  logic             cyc_q, cyc_d;
  logic             err_q, err_d;
  logic [2:0]       cti_q, cti_d;

  logic [15:0]      bsz_in;
  logic [WB_AW-1:0] blen;
  logic             ack_ok;
  logic             err_hit;

  // Zero-length bursts make no sense on the bus, so 0 means a single beat.
  always_comb begin
    bsz_in = cfg_burst_size;
    if (cfg_burst_size == 16'd0) begin
      bsz_in = 16'd1;
    end else if (cfg_burst_size > 16'(MAX_BURST_LEN)) begin
      bsz_in = 16'(MAX_BURST_LEN);
    end
  end

  assign blen    = (rem_q < WB_AW'(bsz_q)) ? rem_q : WB_AW'(bsz_q);
  // An err wins over a simultaneous ack: the beat is not consumed.
  assign err_hit = cyc_q & wbm.wbm_err_i;
  assign ack_ok  = cyc_q & wbm.wbm_ack_i & ~wbm.wbm_err_i;

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    rem_d   = rem_q;
    bsz_d   = bsz_q;
    beat_d  = beat_q;
    cyc_d   = cyc_q;
    cti_d   = cti_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          adr_d   = cfg_start_adr;
          rem_d   = cfg_buf_size;
          bsz_d   = bsz_in;
          err_d   = 1'b0;
          state_d = (cfg_buf_size == '0) ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (WB_AW'(fifo_cnt) >= blen) begin
          beat_d  = blen[15:0];
          cyc_d   = 1'b1;
          cti_d   = (blen == WB_AW'(1)) ? CTI_EOB : CTI_INC;
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        if (err_hit) begin
          err_d   = 1'b1;
          cyc_d   = 1'b0;
          cti_d   = CTI_CLASSIC;
          state_d = ST_DONE;
        end else if (ack_ok) begin
          adr_d  = adr_q + WB_AW'(WSB);
          rem_d  = rem_q - WB_AW'(1);
          beat_d = beat_q - 16'd1;
          // Registered end-of-burst marker lands on the final beat.
          if (beat_q == 16'd2) begin
            cti_d = CTI_EOB;
          end
          if (beat_q == 16'd1) begin
            cyc_d   = 1'b0;
            cti_d   = CTI_CLASSIC;
            state_d = (rem_q == WB_AW'(1)) ? ST_DONE : ST_WAIT;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      adr_q   <= '0;
      rem_q   <= '0;
      bsz_q   <= 16'd1;
      beat_q  <= '0;
      cyc_q   <= 1'b0;
      cti_q   <= CTI_CLASSIC;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      rem_q   <= rem_d;
      bsz_q   <= bsz_d;
      beat_q  <= beat_d;
      cyc_q   <= cyc_d;
      cti_q   <= cti_d;
      err_q   <= err_d;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign irq     = (state_q == ST_DONE);
  assign err     = err_q;
  assign fifo_rd = ack_ok;
  assign state_o = state_q;

  assign wbm.wbm_adr_o = adr_q;
  assign wbm.wbm_dat_o = fifo_d;
  assign wbm.wbm_sel_o = {WSB{cyc_q}};
  assign wbm.wbm_we_o  = cyc_q;
  assign wbm.wbm_cyc_o = cyc_q;
  assign wbm.wbm_stb_o = cyc_q;
  assign wbm.wbm_cti_o = cti_q;
  assign wbm.wbm_bte_o = BTE_LINEAR;

endmodule
